mul: RTL and testbench

//  Iterative shift-add multiplier; the multiply counterpart of the core's divider.

---
 rtl/mul_pkg.sv | 15 +
 rtl/mul.sv | 77 +++++++
 tb/tb_mul.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared widths, types and the operand-magnitude helper for the shift-add multiplier.
package mul_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [2*XLEN-1:0] dword_t;

  // Magnitude as an unsigned word; the most negative value maps to itself.
  function automatic word_t abs_sel(input word_t x, input logic sgn);
    return (sgn && x[XLEN-1]) ? word_t'(~x + word_t'(1)) : x;
  endfunction

endpackage

// File: rtl/mul.sv
// Iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU) with divider-style kick/ready handshake.
// Optional MUL_EARLY_EXIT_EN ends an op once the remaining multiplier bits are all zero.
module mul
  import mul_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kick,
  input  logic             signed_a,
  input  logic             signed_b,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             ready,
  output logic             ready_pre,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      r_bits;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;

  logic               w_busy;
  logic               w_start;
  logic               w_exit;
  logic [WIDTH-1:0]   w_mplier_sh;
  logic [2*WIDTH-1:0] w_prod;

  assign w_busy      = (r_bits != '0);
  assign w_start     = ~w_busy & kick;
  assign w_mplier_sh = r_mplier >> 1;

`ifdef MUL_EARLY_EXIT_EN
  // No set bits left to add: the accumulator already holds the final magnitude.
  assign w_exit    = (w_mplier_sh == '0);
  assign ready_pre = w_busy & ((r_bits == CW'(1)) | w_exit);
`else
  assign w_exit    = 1'b0;
  assign ready_pre = (r_bits == CW'(1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bits   <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
    end else if (w_start) begin
      r_bits   <= CW'(WIDTH);
      r_mcand  <= {{WIDTH{1'b0}}, abs_sel(multiplicand, signed_a)};
      r_mplier <= abs_sel(multiplier, signed_b);
      r_acc    <= '0;
      r_neg    <= (signed_a & multiplicand[WIDTH-1]) ^ (signed_b & multiplier[WIDTH-1]);
    end else if (w_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_sh;
      r_bits   <= w_exit ? '0 : r_bits - CW'(1);
    end
  end

  assign ready  = ~w_busy;
  assign w_prod = r_neg ? (~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_acc;

  assign product_lo = w_prod[WIDTH-1:0];
  assign product_hi = w_prod[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: directed corners plus randomized ops against an arithmetic model.
module tb_mul;

  logic        clk = 1'b0;
  logic        reset;
  logic        kick;
  logic        signed_a;
  logic        signed_b;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        ready;
  logic        ready_pre;
  logic [31:0] product_lo;
  logic [31:0] product_hi;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mul dut (
    .clk          (clk),
    .reset        (reset),
    .kick         (kick),
    .signed_a     (signed_a),
    .signed_b     (signed_b),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .ready_pre    (ready_pre),
    .product_lo   (product_lo),
    .product_hi   (product_hi)
  );

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic sa, input logic sb);
    logic signed [65:0] xa;
    logic signed [65:0] xb;
    logic signed [65:0] p;
    xa = sa ? {{34{a[31]}}, a} : {34'b0, a};
    xb = sb ? {{34{b[31]}}, b} : {34'b0, b};
    p  = xa * xb;
    return p[63:0];
  endfunction

  function automatic int model_lat(input logic [31:0] b, input logic sb);
`ifdef MUL_EARLY_EXIT_EN
    longint v;
    int     n;
    v = sb ? longint'($signed(b)) : longint'({32'b0, b});
    if (v < 0) v = -v;
    n = 0;
    while (v != 0) begin
      n++;
      v = v >>> 1;
    end
    return (n == 0) ? 1 : n;
`else
    return 32 + 0 * int'(b[0] ^ sb);
`endif
  endfunction

  // Starts an op from a falling edge, tracks it to completion, and checks latency,
  // ready_pre timing and the product. Returns on the falling edge where ready is high.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sa, input logic sb, input int busy_kick_at);
    logic [63:0] exp;
    int          exp_lat;
    int          lat;
    int          pre_hits;
    logic        last_pre;
    exp     = model_prod(a, b, sa, sb);
    exp_lat = model_lat(b, sb);
    kick = 1'b1; multiplicand = a; multiplier = b; signed_a = sa; signed_b = sb;
    @(posedge clk); #1;
    kick = 1'b0;
    multiplicand = $urandom; multiplier = $urandom;
    signed_a = 1'($urandom_range(0, 1)); signed_b = 1'($urandom_range(0, 1));
    @(negedge clk);
    lat = 0; pre_hits = 0; last_pre = 1'b0;
    while (ready !== 1'b1 && lat < 100) begin
      if (ready_pre === 1'b1) pre_hits++;
      last_pre = ready_pre;
      kick = (lat == busy_kick_at);
      if (kick) begin
        multiplicand = $urandom; multiplier = $urandom;
      end
      lat++;
      @(negedge clk);
    end
    kick = 1'b0;
    n_checks++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
    else n_pass++;
    n_checks++;
    if (pre_hits !== 1 || last_pre !== 1'b1)
      $display("FAIL %s ready_pre: high %0d cycles (last busy=%0b), expected 1 (last busy=1)", name, pre_hits, last_pre);
    else n_pass++;
    n_checks++;
    if ({product_hi, product_lo} !== exp)
      $display("FAIL %s product: got %h_%h, expected %h_%h", name, product_hi, product_lo, exp[63:32], exp[31:0]);
    else n_pass++;
    n_checks++;
    if (ready_pre !== 1'b0) $display("FAIL %s ready_pre_idle: got %b, expected 0", name, ready_pre);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1; kick = 1'b0; signed_a = 1'b0; signed_b = 1'b0;
    multiplicand = '0; multiplier = '0;
    #3;
    n_checks++;
    if ({ready, ready_pre, product_hi, product_lo} !== {1'b1, 1'b0, 64'h0})
      $display("FAIL reset_state: got ready=%b pre=%b prod=%h_%h, expected 1 0 0", ready, ready_pre, product_hi, product_lo);
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ready, ready_pre, product_hi, product_lo} !== {1'b1, 1'b0, 64'h0})
      $display("FAIL post_reset_idle: got ready=%b pre=%b prod=%h_%h, expected 1 0 0", ready, ready_pre, product_hi, product_lo);
    else n_pass++;
  endtask

  task automatic test_unsigned_max;
    run_op("mulhu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
    @(negedge clk);
  endtask

  task automatic test_signed;
    run_op("mulh_m7x3", 32'hFFFF_FFF9, 32'd3, 1'b1, 1'b1, -1);
    run_op("mulh_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, -1);
    run_op("mulh_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, -1);
    @(negedge clk);
  endtask

  task automatic test_mulhsu;
    run_op("mulhsu_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, -1);
    @(negedge clk);
  endtask

  task automatic test_kick_busy;
    run_op("kick_busy", 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_first", 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0, -1);
    run_op("b2b_second", 32'h0000_1234, 32'hFFFF_FF00, 1'b0, 1'b1, -1);
  endtask

  task automatic test_hold;
    logic [63:0] held;
    held = model_prod(32'h7FFF_FFFF, 32'h0000_0003, 1'b1, 1'b1);
    run_op("hold_op", 32'h7FFF_FFFF, 32'h0000_0003, 1'b1, 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      multiplicand = $urandom; multiplier = $urandom;
      signed_a = 1'($urandom_range(0, 1)); signed_b = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    n_checks++;
    if ({ready, product_hi, product_lo} !== {1'b1, held})
      $display("FAIL hold_result: got ready=%b prod=%h_%h, expected 1 %h", ready, product_hi, product_lo, held);
    else n_pass++;
  endtask

  task automatic test_early_exit;
    run_op("b_zero", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, -1);
    run_op("b_five", 32'hFFFF_FFF0, 32'd5, 1'b1, 1'b0, -1);
    run_op("b_neg_five", 32'h0000_0011, 32'hFFFF_FFFB, 1'b0, 1'b1, -1);
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 1) b = b >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      if (i % 3 == 0) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    kick = 1'b1; multiplicand = 32'hFFFF_FFFF; multiplier = 32'hFFFF_FFFF;
    signed_a = 1'b0; signed_b = 1'b0;
    @(posedge clk); #1;
    kick = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (ready !== 1'b0 || {product_hi, product_lo} === 64'h0)
      $display("FAIL midop_busy: got ready=%b prod=%h_%h, expected 0 and nonzero partial", ready, product_hi, product_lo);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({ready, ready_pre, product_hi, product_lo} !== {1'b1, 1'b0, 64'h0})
      $display("FAIL reset_midop: got ready=%b pre=%b prod=%h_%h, expected 1 0 0", ready, ready_pre, product_hi, product_lo);
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    run_op("after_reset", 32'd6, 32'd7, 1'b0, 1'b0, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_mulhsu();
    test_kick_busy();
    test_back_to_back();
    test_hold();
    test_early_exit();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
